div_seq_ctrl: RTL and testbench

// - Multi-cycle sequencer for the RV32M divide/remainder ops (DIV, DIVU, REM, REMU).
// - These ops have no single-cycle path in the EX-stage ALU.
// - Sits beside the ALU in EX; the core holds the pipeline on busy and latches result on done.
// - Radix-2 restoring divider on operand magnitudes, followed by a sign-fix step.

---
 rtl/div_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_div_seq_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU.
// Radix-2 restoring divide on operand magnitudes, then a one-cycle sign fix.
// Optional build macro: DIV_EARLY_OUT_EN (skip CALC when |src1| < |src2|).
module div_seq_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state, state_n;
  logic [XLEN-1:0]  quo, rem, dvs;
  logic [CNT_W-1:0] count;
  logic             sel_rem_q, neg1_q, neg2_q, fix_q;

  logic             accept, is_signed, s1_neg, s2_neg;
  logic [XLEN-1:0]  mag1, mag2;
  logic             div0, ovf, special, early;
  logic [XLEN:0]    rem_t;
  logic             ge;
  logic [XLEN-1:0]  rem_step, quo_step, q_fix, r_fix;
  logic             fin_commit, busy_n;

  // Issue decode: operand magnitudes, sign flags and special-case detection
  always_comb begin
    accept    = (state == S_IDLE) && start && !flush;
    is_signed = !op[0];
    s1_neg    = is_signed && src1[XLEN-1];
    s2_neg    = is_signed && src2[XLEN-1];
    mag1      = s1_neg ? XLEN'(-src1) : src1;
    mag2      = s2_neg ? XLEN'(-src2) : src2;
    div0      = (src2 == ZERO);
    ovf       = is_signed && (src1 == MIN_NEG) && (src2 == ALL_ONES);
    special   = div0 || ovf;
`ifdef DIV_EARLY_OUT_EN
    early     = !div0 && (mag1 < mag2);
`else
    early     = 1'b0;
`endif
  end

  // One restoring step plus the FIN sign fix
  always_comb begin
    rem_t    = {rem, quo[XLEN-1]};
    ge       = (rem_t >= {1'b0, dvs});
    rem_step = ge ? XLEN'(rem_t - {1'b0, dvs}) : rem_t[XLEN-1:0];
    quo_step = {quo[XLEN-2:0], ge};
    q_fix    = (fix_q && (neg1_q ^ neg2_q)) ? XLEN'(-quo) : quo;
    r_fix    = (fix_q && neg1_q) ? XLEN'(-rem) : rem;
  end

  // Next-state logic
  always_comb begin
    state_n    = state;
    fin_commit = 1'b0;
    case (state)
      S_IDLE: if (accept) state_n = (special || early) ? S_FIN : S_CALC;
      S_CALC: begin
        if (flush)                   state_n = S_IDLE;
        else if (count == '0)        state_n = S_FIN;
      end
      S_FIN: begin
        state_n    = S_IDLE;
        fin_commit = !flush;
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n == S_CALC) || (state_n == S_FIN);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Datapath, operand latch and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      count     <= '0;
      sel_rem_q <= 1'b0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      fix_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      if (accept) begin
        sel_rem_q <= op[1];
        neg1_q    <= s1_neg;
        neg2_q    <= s2_neg;
        fix_q     <= is_signed && !special;
        dvs       <= mag2;
        count     <= CNT_W'(XLEN - 1);
        if (div0) begin
          quo <= ALL_ONES;
          rem <= src1;
        end else if (ovf) begin
          quo <= MIN_NEG;
          rem <= ZERO;
        end else if (early) begin
          quo <= ZERO;
          rem <= mag1;
        end else begin
          quo <= mag1;
          rem <= ZERO;
        end
      end else if ((state == S_CALC) && !flush) begin
        quo   <= quo_step;
        rem   <= rem_step;
        count <= count - CNT_W'(1);
      end
      if (fin_commit) result <= sel_rem_q ? r_fix : q_fix;
      busy <= busy_n;
      done <= fin_commit;
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed tests for div_seq_ctrl.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] src1, src2;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SMALL = 1;
`else
  localparam int LAT_SMALL = 33;
`endif

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Issue one op (accepted at edge T) and wait for done; lat = cycles after T
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    res = result;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat; logic [31:0] res;
    run_op(OP_DIVU, 32'd100, 32'd7, lat, res);
    n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu_100_7 got=%h exp=%h", res, 32'd14); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu_100_7_lat got=%0d exp=33", lat); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse got=%b exp=0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done got=%b exp=0", busy); end
  endtask

  task automatic test_signed;
    int lat; logic [31:0] res;
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, lat, res);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_m7_2 got=%h exp=ffffffff", res); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL rem_m7_2_lat got=%0d exp=33", lat); end
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, res);
    n_checks++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_m7_2 got=%h exp=fffffffd", res); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div_m7_2_lat got=%0d exp=33", lat); end
    run_op(OP_DIV, 32'd20, 32'hFFFF_FFFA, lat, res);
    n_checks++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_20_m6 got=%h exp=fffffffd", res); end
    run_op(OP_REM, 32'd20, 32'hFFFF_FFFA, lat, res);
    n_checks++; if (res !== 32'd2) begin n_fail++; $display("FAIL rem_20_m6 got=%h exp=2", res); end
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'd10, lat, res);
    n_checks++; if (res !== 32'd5) begin n_fail++; $display("FAIL remu_max_10 got=%h exp=5", res); end
  endtask

  task automatic test_special;
    int lat; logic [31:0] res;
    run_op(OP_DIV, 32'd5, 32'd0, lat, res);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_5_0 got=%h exp=ffffffff", res); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL div_5_0_lat got=%0d exp=1", lat); end
    run_op(OP_REMU, 32'd5, 32'd0, lat, res);
    n_checks++; if (res !== 32'd5) begin n_fail++; $display("FAIL remu_5_0 got=%h exp=5", res); end
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd0, lat, res);
    n_checks++; if (res !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL rem_m7_0 got=%h exp=fffffff9", res); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
    n_checks++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf got=%h exp=80000000", res); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL div_ovf_lat got=%0d exp=1", lat); end
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL rem_ovf got=%h exp=0", res); end
  endtask

  task automatic test_small;
    int lat; logic [31:0] res;
    run_op(OP_DIVU, 32'd3, 32'd10, lat, res);
    n_checks++; if (res !== 32'd0) begin n_fail++; $display("FAIL divu_3_10 got=%h exp=0", res); end
    n_checks++; if (lat !== LAT_SMALL) begin n_fail++; $display("FAIL divu_3_10_lat got=%0d exp=%0d", lat, LAT_SMALL); end
    run_op(OP_REMU, 32'd3, 32'd10, lat, res);
    n_checks++; if (res !== 32'd3) begin n_fail++; $display("FAIL remu_3_10 got=%h exp=3", res); end
    run_op(OP_REM, 32'hFFFF_FFFD, 32'd10, lat, res);
    n_checks++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL rem_m3_10 got=%h exp=fffffffd", res); end
  endtask

  task automatic test_start_busy;
    int lat; logic [31:0] res;
    // DIVU 100/7 accepted at T; a stray DIVU 50/5 start in CALC must be dropped
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; src1 = 32'd100; src2 = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) begin
        start = 1'b1; op = OP_DIVU; src1 = 32'd50; src2 = 32'd5;
      end
      @(posedge clk);
      #1;
      if (k == 3) begin
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_in_calc_busy got=%b exp=1", busy); end
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    res = result;
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL start_in_calc_lat got=%0d exp=33", lat); end
    n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL start_in_calc_res got=%h exp=%h", res, 32'd14); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stray_start_queued busy=%b exp=0", busy); end
  endtask

  task automatic test_flush;
    int seen;
    // Prior result is 14; flushed DIVU 1000/10 must leave it untouched
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; src1 = 32'd1000; src2 = 32'd10;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", busy); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
    n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL flush_result got=%h exp=%h", result, 32'd14); end
    // flush together with start in IDLE: start ignored
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_DIV; src1 = 32'd5; src2 = 32'd0;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_start_done got=%b exp=0", done); end
  endtask

  task automatic test_rst_mid;
    int lat, seen; logic [31:0] res;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; src1 = 32'd100; src2 = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got=%b exp=0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL rst_mid_result got=%h exp=0", result); end
    @(negedge clk) rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_done got=%0d exp=0", seen); end
    run_op(OP_DIVU, 32'd100, 32'd7, lat, res);
    n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL rst_recover got=%h exp=%h", res, 32'd14); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL rst_recover_lat got=%0d exp=33", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_special();
    test_small();
    test_start_busy();
    test_flush();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
